// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with pending-write scoreboard and RAW hazard flags
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [XLEN-1:0] rd_data_a,
    output logic [XLEN-1:0] rd_data_b,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic            haz_a,
    output logic            haz_b,
    output logic            stall,
    output logic [AW:0]     busy_cnt,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_nxt;
    logic            wr_ok;

    assign wr_ok = wr_en && !(ZR && (wr_addr == '0));

    // Clear from writeback first, then set from issue, so a same-edge issue wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_en) busy_nxt[wr_addr] = 1'b0;
        if (iss_en && !(ZR && (iss_rd == '0))) busy_nxt[iss_rd] = 1'b1;
        if (flush) busy_nxt = '0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_ok) mem[wr_addr] <= wr_data;
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        if (ZR && (rd_addr_a == '0))
            rd_data_a = '0;
        else if (BP && wr_ok && (wr_addr == rd_addr_a))
            rd_data_a = wr_data;
        else
            rd_data_a = mem[rd_addr_a];

        if (ZR && (rd_addr_b == '0))
            rd_data_b = '0;
        else if (BP && wr_ok && (wr_addr == rd_addr_b))
            rd_data_b = wr_data;
        else
            rd_data_b = mem[rd_addr_b];
    end

    assign dbg_data = (ZR && (dbg_addr == '0)) ? '0 : mem[dbg_addr];

    // A writeback landing this cycle resolves the hazard only when its data is forwarded.
    assign haz_a = busy[rd_addr_a] && !(ZR && (rd_addr_a == '0))
                 && !(BP && wr_en && (wr_addr == rd_addr_a));
    assign haz_b = busy[rd_addr_b] && !(ZR && (rd_addr_b == '0))
                 && !(BP && wr_en && (wr_addr == rd_addr_b));
    assign stall    = haz_a | haz_b;
    assign busy_cnt = cnt_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the RV32 pipeline core, with a built-in pending-write scoreboard. It provides two combinational read ports, one write port and a write-to-read bypass. A hardwired-zero register 0 is selectable. Per-register busy bits are set at issue and cleared at writeback, so the decode stage gets RAW-hazard flags and a stall request without a separate hazard unit. It sits between decode (read/issue) and writeback, and replaces the fixed 32x32 register file.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers (power of two, >= 2)
- AW, $clog2(NREG), register address width
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and busy clear visible same cycle

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  writeback write enable
- wr_addr  in  AW  writeback destination register
- wr_data  in  XLEN  writeback data
- rd_addr_a / rd_addr_b  in  AW  read addresses (rs1/rs2)
- rd_data_a / rd_data_b  out  XLEN  read data, combinational
- iss_en  in  1  instruction issued this cycle with a destination register
- iss_rd  in  AW  destination of issued instruction
- flush  in  1  clear all busy bits (pipeline flush)
- haz_a / haz_b  out  1  read source is pending a write
- stall  out  1  haz_a | haz_b
- busy_cnt  out  AW+1  number of busy registers
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  debug read data (no bypass)

## Operation
- Storage is NREG x XLEN. Sync reset clears every register and every busy bit to 0.
- Reset values: rd_data_a/b = 0, dbg_data = 0, haz_a/b = 0, stall = 0, busy_cnt = 0.
- Write: when wr_en = 1 and not (ZERO_REG and wr_addr = 0), mem[wr_addr] <= wr_data on the clock edge. rst has priority over wr_en.
- Read: rd_data_x = mem[rd_addr_x]. The override order is as follows, highest priority first:
  - ZERO_REG and address 0 -> 0;
  - BYPASS and wr_en and wr_addr = rd_addr_x (nonzero-filtered) -> wr_data;
  - otherwise mem[rd_addr_x].
- Scoreboard:
  - On each edge, busy[wr_addr] clears if wr_en = 1.
  - Then busy[iss_rd] sets if iss_en = 1, so the set wins when iss_rd = wr_addr.
  - flush clears all busy bits and overrides both the set and the clear.
  - rst clears all busy bits and overrides flush.
  - busy[0] is never set when ZERO_REG = 1.
  - Issuing to an already-busy register leaves it busy, with a single bit of state; no counter per register.
- Hazard: haz_x = busy[rd_addr_x] and not (ZERO_REG and rd_addr_x = 0) and not (BYPASS and wr_en and wr_addr = rd_addr_x).
  - With BYPASS = 0, a same-cycle writeback does not suppress the hazard; the flag drops the cycle after.
- busy_cnt is the registered population count of busy bits. It is updated on the same edge as the busy bits.
- All operations are single-cycle; the block has no other state machine.

## Timing
- Read latency is 0 cycles (combinational from address). Write latency is 1 edge.
- Without BYPASS, written data is visible on read ports the cycle after wr_en.
- busy set by iss_en at edge N: haz visible from cycle N+1.
- busy clear by wr_en at edge N: with BYPASS, haz drops during cycle N itself; without BYPASS, from N+1.
- flush at edge N: all haz/stall = 0 and busy_cnt = 0 from cycle N+1.
- rst asserted mid-operation: the next edge discards any concurrent wr_en/iss_en/flush and returns to the reset state.
- wr_addr / iss_rd / rd_addr out of range cannot occur (NREG is a power of two).

## Test plan
- Reset, then read all 32 addresses -> all 0; busy_cnt = 0; stall = 0.
- wr_en, wr_addr = 5, wr_data = 0xDEADBEEF, with rd_addr_a = 5 in the same cycle -> rd_data_a = 0xDEADBEEF that cycle (BYPASS = 1), and 0xDEADBEEF from mem the next cycle. Repeat with BYPASS = 0 -> old value 0 that cycle.
- wr_en to addr 0 with 0x1234 -> rd_data_a(addr 0) = 0 and dbg_data(0) = 0. With ZERO_REG = 0 -> reads 0x1234 next cycle.
- Scoreboard path:
  - iss_en, iss_rd = 7 -> next cycle rd_addr_b = 7 gives haz_b = 1, stall = 1, busy_cnt = 1.
  - Writeback to 7 -> haz_b = 0 in the same cycle (BYPASS), busy_cnt = 0 after the edge.
- Simultaneous iss_en iss_rd = 9 and wr_en wr_addr = 9 -> busy[9] = 1 after the edge. Also issue to 3, 4, 9, then flush -> busy_cnt = 0 and all haz = 0.
- rst asserted in the same cycle as wr_en (addr 2, 0xFF) and iss_en (rd 2) -> after the edge, reg 2 = 0, busy_cnt = 0.
